// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded OrgaSmall fields into a high/low word pair and
// writes both words to program memory at an auto-incrementing write pointer.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef OPCODE_BITS
`define OPCODE_BITS 5
`endif
`ifndef REGISTER_BITS
`define REGISTER_BITS 3
`endif
`ifndef IMM_BITS
`define IMM_BITS `WORD_SIZE
`endif

module inst_encoder #(
  parameter int ADDR_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [`OPCODE_BITS-1:0]   opcode,
  input  logic [`REGISTER_BITS-1:0] rx,
  input  logic [`REGISTER_BITS-1:0] ry,
  input  logic [`IMM_BITS-1:0]      imm,
  input  logic                      use_imm,
  input  logic                      base_load,
  input  logic [ADDR_BITS-1:0]      base_addr,
  input  logic                      mem_ready,
  output logic                      mem_we,
  output logic [ADDR_BITS-1:0]      mem_addr,
  output logic [`WORD_SIZE-1:0]     mem_data,
  output logic [ADDR_BITS-1:0]      wr_ptr,
  output logic [15:0]               inst_count
);
  localparam int WORD_W = `WORD_SIZE;
  localparam int OPC_W  = `OPCODE_BITS;
  localparam int REG_W  = `REGISTER_BITS;

  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]          inst_count_q, inst_count_d;
  logic [WORD_W-1:0]    hi_q, hi_d, lo_q, lo_d;

  // Inverse of the decoder: opcode at the top, rx at the bottom, zeros between.
  function automatic logic [WORD_W-1:0] encode_hi(input logic [OPC_W-1:0] op,
                                                  input logic [REG_W-1:0] ra);
    encode_hi = (WORD_W'(op) << (WORD_W - OPC_W)) | WORD_W'(ra);
  endfunction

  function automatic logic [WORD_W-1:0] encode_lo(input logic [REG_W-1:0]  rb,
                                                  input logic [WORD_W-1:0] im,
                                                  input logic              sel_imm);
    encode_lo = sel_imm ? im : (WORD_W'(rb) << (WORD_W - REG_W));
  endfunction

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    inst_count_d = inst_count_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    unique case (state_q)
      IDLE: begin
        if (base_load) wr_ptr_d = base_addr;
        if (in_valid) begin
          hi_d    = encode_hi(opcode, rx);
          lo_d    = encode_lo(ry, imm, use_imm);
          state_d = WR_HI;
        end
      end
      WR_HI: if (mem_ready) state_d = WR_LO;
      WR_LO: if (mem_ready) begin
        wr_ptr_d     = wr_ptr_q + ADDR_BITS'(2);
        inst_count_d = inst_count_q + 16'd1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      inst_count_q <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      inst_count_q <= inst_count_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  // Memory-side outputs depend on registered state only.
  always_comb begin
    in_ready = (state_q == IDLE);
    mem_we   = (state_q != IDLE);
    mem_addr = (state_q == WR_LO) ? wr_ptr_q + ADDR_BITS'(1) : wr_ptr_q;
    mem_data = '0;
    if (state_q == WR_HI) mem_data = hi_q;
    if (state_q == WR_LO) mem_data = lo_q;
  end

  assign wr_ptr     = wr_ptr_q;
  assign inst_count = inst_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed encodings, stalls, pointer
// wrap, base_load corner cases and mid-write reset.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef OPCODE_BITS
`define OPCODE_BITS 5
`endif
`ifndef REGISTER_BITS
`define REGISTER_BITS 3
`endif
`ifndef IMM_BITS
`define IMM_BITS `WORD_SIZE
`endif

module tb_inst_encoder;
  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [`OPCODE_BITS-1:0]   opcode;
  logic [`REGISTER_BITS-1:0] rx, ry;
  logic [`IMM_BITS-1:0]      imm;
  logic                      use_imm;
  logic                      base_load;
  logic [7:0]                base_addr;
  logic                      mem_ready;
  logic                      mem_we;
  logic [7:0]                mem_addr;
  logic [`WORD_SIZE-1:0]     mem_data;
  logic [7:0]                wr_ptr;
  logic [15:0]               inst_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  log_addr[$];
  logic [7:0]  log_data[$];
  logic        snap_wr;
  logic [7:0]  snap_addr, snap_data;

  inst_encoder #(.ADDR_BITS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rx(rx), .ry(ry), .imm(imm), .use_imm(use_imm),
    .base_load(base_load), .base_addr(base_addr), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .wr_ptr(wr_ptr), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  // Snapshot the write port mid-low-phase; the following rising edge commits it.
  always begin
    @(negedge clk);
    #1;
    snap_wr   = mem_we && mem_ready && !rst;
    snap_addr = mem_addr;
    snap_data = mem_data;
  end

  always @(posedge clk) begin
    if (snap_wr) begin
      log_addr.push_back(snap_addr);
      log_data.push_back(snap_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One instruction through the encoder; drives at falling edges, checks there too.
  task automatic send(input string tag,
                      input logic [4:0] op, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [7:0] im, input logic ui,
                      input logic bl, input logic [7:0] ba,
                      input int hs, input int ls, input logic bl_in_lo,
                      input logic [7:0] e_hi_a, input logic [7:0] e_hi,
                      input logic [7:0] e_lo_a, input logic [7:0] e_lo);
    int n0;
    int cyc;
    n0 = log_addr.size();
    cyc = 0;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    opcode = op; rx = ra; ry = rb; imm = im; use_imm = ui;
    base_load = bl; base_addr = ba; in_valid = 1'b1; mem_ready = 1'b1;
    @(negedge clk); cyc++;
    in_valid = 1'b0; base_load = 1'b0;
    opcode = ~op; rx = ~ra; ry = ~rb; imm = ~im; use_imm = ~ui;
    for (int i = 0; i <= hs; i++) begin
      chk({tag, "_hi_we"},   32'(mem_we),   32'd1);
      chk({tag, "_hi_addr"}, 32'(mem_addr), 32'(e_hi_a));
      chk({tag, "_hi_data"}, 32'(mem_data), 32'(e_hi));
      mem_ready = (i == hs);
      @(negedge clk); cyc++;
    end
    if (bl_in_lo) begin
      base_load = 1'b1; base_addr = 8'h40;
    end
    for (int i = 0; i <= ls; i++) begin
      chk({tag, "_lo_we"},   32'(mem_we),   32'd1);
      chk({tag, "_lo_addr"}, 32'(mem_addr), 32'(e_lo_a));
      chk({tag, "_lo_data"}, 32'(mem_data), 32'(e_lo));
      mem_ready = (i == ls);
      @(negedge clk); cyc++;
    end
    base_load = 1'b0;
    mem_ready = 1'b1;
    chk({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_done_we"},    32'(mem_we),   32'd0);
    chk({tag, "_latency"},    32'(cyc),      32'(3 + hs + ls));
    chk({tag, "_nwrites"},    32'(log_addr.size() - n0), 32'd2);
    if (log_addr.size() >= n0 + 2) begin
      chk({tag, "_log_hi_a"}, 32'(log_addr[n0]),     32'(e_hi_a));
      chk({tag, "_log_hi_d"}, 32'(log_data[n0]),     32'(e_hi));
      chk({tag, "_log_lo_a"}, 32'(log_addr[n0 + 1]), 32'(e_lo_a));
      chk({tag, "_log_lo_d"}, 32'(log_data[n0 + 1]), 32'(e_lo));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; rx = '0; ry = '0; imm = '0;
    use_imm = 1'b0; base_load = 1'b0; base_addr = '0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready),   32'd1);
    chk("rst_we",    32'(mem_we),     32'd0);
    chk("rst_addr",  32'(mem_addr),   32'd0);
    chk("rst_data",  32'(mem_data),   32'd0);
    chk("rst_ptr",   32'(wr_ptr),     32'd0);
    chk("rst_cnt",   32'(inst_count), 32'd0);
    rst = 1'b0;

    send("t1", 5'h03, 3'd2, 3'd5, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0,
         8'h00, 8'h1A, 8'h01, 8'hA0);
    chk("t1_ptr",  32'(wr_ptr),     32'd2);
    chk("t1_cnt",  32'(inst_count), 32'd1);
    chk("t1_addr", 32'(mem_addr),   32'd2);
    chk("t1_data", 32'(mem_data),   32'd0);

    send("t2", 5'h10, 3'd7, 3'd0, 8'h7F, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0,
         8'h02, 8'h87, 8'h03, 8'h7F);
    chk("t2_ptr", 32'(wr_ptr),     32'd4);
    chk("t2_cnt", 32'(inst_count), 32'd2);

    send("stall", 5'h1F, 3'd1, 3'd0, 8'h55, 1'b1, 1'b0, 8'h00, 3, 2, 1'b0,
         8'h04, 8'hF9, 8'h05, 8'h55);
    chk("stall_ptr", 32'(wr_ptr),     32'd6);
    chk("stall_cnt", 32'(inst_count), 32'd3);

    send("wrap", 5'h01, 3'd0, 3'd7, 8'h00, 1'b0, 1'b1, 8'hFF, 0, 0, 1'b0,
         8'hFF, 8'h08, 8'h00, 8'hE0);
    chk("wrap_ptr", 32'(wr_ptr),     32'd1);
    chk("wrap_cnt", 32'(inst_count), 32'd4);

    send("bl_lo", 5'h02, 3'd3, 3'd1, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 1'b1,
         8'h01, 8'h13, 8'h02, 8'h20);
    chk("bl_lo_ptr", 32'(wr_ptr),     32'd3);
    chk("bl_lo_cnt", 32'(inst_count), 32'd5);

    // Reset while the high word is pending.
    n0 = log_addr.size();
    @(negedge clk);
    opcode = 5'h05; rx = 3'd4; imm = 8'h33; use_imm = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstw_hi_we", 32'(mem_we), 32'd1);
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    chk("rstw_we",    32'(mem_we),     32'd0);
    chk("rstw_ready", 32'(in_ready),   32'd1);
    chk("rstw_ptr",   32'(wr_ptr),     32'd0);
    chk("rstw_cnt",   32'(inst_count), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rstw_idle_we", 32'(mem_we), 32'd0);
    end
    chk("rstw_nwrites", 32'(log_addr.size() - n0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
